// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame controller: state encoding,
// error codes, default header byte and the byte-time helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_CSUM    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0] DEFAULT_HEADER = 8'h55;

    // One byte on the wire is 10 bit times (start + 8 data + stop).
    function automatic int byte_time(input int clk_freq, input int baud_rate);
        return 10 * (clk_freq / baud_rate);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: synchronous write port, combinational read port.
module uart_frame_buf #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Sequences UART receive bytes into HEADER/LEN/payload/CSUM frames and
// releases only fully validated payloads on a valid/ready byte stream.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         CLK_FREQ      = 5_000_000,
    parameter int         BAUD_RATE     = 9600,
    parameter logic [7:0] HEADER        = DEFAULT_HEADER,
    parameter int         MAX_LEN       = 16,
    parameter int         TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * byte_time(CLK_FREQ, BAUD_RATE);
    localparam int PTR_W  = $clog2(MAX_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, len_reg;
    logic [7:0]       sum_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             frame_ok_reg, frame_err_reg;
    logic [1:0]       err_code_reg;

    logic             err_event, ok_event;
    logic [1:0]       err_code_next;
    logic             timed_state, timed_next, tmo_expired;
    logic             buf_we, xfer, last_beat;
    logic [7:0]       buf_rdata;

    assign timed_state = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) || (state_reg == ST_CSUM);
    assign timed_next  = (state_next == ST_LEN) || (state_next == ST_PAYLOAD) || (state_next == ST_CSUM);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign tmo_expired = timed_state && !rx_valid && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
    assign buf_we      = (state_reg == ST_PAYLOAD) && rx_valid;
    assign xfer        = (state_reg == ST_DRAIN) && out_ready;
    assign last_beat   = (rd_ptr_reg == len_reg - PTR_W'(1));

    uart_frame_buf #(
        .ADDR_W(BUF_AW)
    ) u_buf (
        .clk  (clk),
        .we   (buf_we),
        .waddr(wr_ptr_reg[BUF_AW-1:0]),
        .wdata(rx_data),
        .raddr(rd_ptr_reg[BUF_AW-1:0]),
        .rdata(buf_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        err_event     = 1'b0;
        err_code_next = ERR_CSUM;
        ok_event      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rx_valid && rx_data == HEADER) begin
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || int'(rx_data) > MAX_LEN) begin
                        state_next    = ST_IDLE;
                        err_event     = 1'b1;
                        err_code_next = ERR_LEN;
                    end else begin
                        state_next = ST_PAYLOAD;
                    end
                end else if (tmo_expired) begin
                    state_next    = ST_IDLE;
                    err_event     = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    if (wr_ptr_reg == len_reg - PTR_W'(1)) begin
                        state_next = ST_CSUM;
                    end
                end else if (tmo_expired) begin
                    state_next    = ST_IDLE;
                    err_event     = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == sum_reg) begin
                        state_next = ST_DRAIN;
                        ok_event   = 1'b1;
                    end else begin
                        state_next    = ST_IDLE;
                        err_event     = 1'b1;
                        err_code_next = ERR_CSUM;
                    end
                end else if (tmo_expired) begin
                    state_next    = ST_IDLE;
                    err_event     = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (xfer && last_beat) begin
                    state_next = ST_IDLE;
                end
                // The receiver cannot be stalled, so bytes landing here are lost.
                if (rx_valid) begin
                    err_event     = 1'b1;
                    err_code_next = ERR_OVERRUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'd0;
        out_last  = 1'b0;
        busy      = (state_reg != ST_IDLE);
        if (state_reg == ST_DRAIN) begin
            out_valid = 1'b1;
            out_data  = buf_rdata;
            out_last  = last_beat;
        end
    end

    assign frame_ok  = frame_ok_reg;
    assign frame_err = frame_err_reg;
    assign err_code  = err_code_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            len_reg       <= '0;
            sum_reg       <= 8'd0;
            tmo_cnt_reg   <= '0;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            err_code_reg  <= ERR_CSUM;
        end else begin
            frame_ok_reg  <= ok_event;
            frame_err_reg <= err_event;
            if (err_event) begin
                err_code_reg <= err_code_next;
            end

            if (!timed_next || rx_valid || state_next != state_reg) begin
                tmo_cnt_reg <= '0;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end

            if (state_reg == ST_LEN && rx_valid) begin
                len_reg    <= rx_data[PTR_W-1:0];
                sum_reg    <= rx_data;
                wr_ptr_reg <= '0;
            end
            if (buf_we) begin
                sum_reg    <= sum_reg + rx_data;
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end

            if (ok_event) begin
                rd_ptr_reg <= '0;
            end else if (xfer && !last_beat) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

endmodule
